// File: rtl/load_store_unit.sv
// RV32I data-memory initiator: aligns stores, extracts/extends loads, splits word-crossing accesses.
// Latency 2 cycles (3 when split, 1 on error); one request in flight, req_ready_o only in IDLE, no response stall.
module load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter int MEM_DEPTH        = 1024,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    output logic                  resp_valid_o,
    output logic [31:0]           resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_strb_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [1:0] sz);
        case (sz)
            2'b00:   mask_of = 4'b0001;
            2'b01:   mask_of = 4'b0011;
            default: mask_of = 4'b1111;
        endcase
    endfunction

    // pair holds {second word, first word}; the byte at off lands in bits [7:0]
    function automatic logic [31:0] load_extract(input logic [63:0] pair, input logic [1:0] off,
                                                 input logic [2:0] f3);
        logic [63:0] s;
        s = pair >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{24{s[7]}}, s[7:0]};
            3'b001:  load_extract = {{16{s[15]}}, s[15:0]};
            3'b010:  load_extract = s[31:0];
            3'b100:  load_extract = {24'd0, s[7:0]};
            3'b101:  load_extract = {16'd0, s[15:0]};
            default: load_extract = 32'd0;
        endcase
    endfunction

    logic [1:0]            state_q, state_d;
    logic                  we_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           lo_buf_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    // request decode, evaluated on the live inputs at the acceptance edge
    logic [2:0]          req_size;
    logic                req_cross;
    logic [ADDR_WIDTH:0] req_end;
    logic                req_oor;
    logic                req_illegal;
    logic                req_err;

    assign req_size  = size_of(req_funct3_i[1:0]);
    assign req_cross = ({1'b0, req_addr_i[1:0]} + req_size) > 3'd4;
    assign req_end   = {1'b0, req_addr_i} + {{(ADDR_WIDTH-2){1'b0}}, req_size}
                       - {{ADDR_WIDTH{1'b0}}, 1'b1};
    assign req_oor   = req_end[ADDR_WIDTH:2] >= (ADDR_WIDTH-1)'(MEM_DEPTH);

    always_comb begin
        req_illegal = 1'b0;
        if (req_we_i)
            req_illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010});
        else
            req_illegal = req_funct3_i inside {3'b011, 3'b110, 3'b111};
    end

    assign req_err = req_illegal || req_oor || (req_cross && !SPLIT_MISALIGNED);

    logic [1:0]            off_q;
    logic [3:0]            mask_q;
    logic                  cross_q;
    logic [7:0]            strb_lo;
    logic [2:0]            hi_shift;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign off_q     = addr_q[1:0];
    assign mask_q    = mask_of(funct3_q[1:0]);
    assign cross_q   = ({1'b0, off_q} + size_of(funct3_q[1:0])) > 3'd4;
    assign strb_lo   = {4'b0000, mask_q} << off_q;
    assign hi_shift  = 3'd4 - {1'b0, off_q};
    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid_i) state_d = req_err ? S_RESP : S_ACC0;
            S_ACC0: state_d = cross_q ? S_ACC1 : S_RESP;
            S_ACC1: state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // rst also gates the port so a split store caught by reset never issues its second half
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        if (!rst && state_q == S_ACC0) begin
            mem_addr_o = word_addr;
            mem_we_o   = we_q;
            if (we_q) begin
                mem_strb_o  = strb_lo[3:0];
                mem_wdata_o = wdata_q << {off_q, 3'b000};
            end
        end else if (!rst && state_q == S_ACC1) begin
            mem_addr_o = word_addr + ADDR_WIDTH'(4);
            mem_we_o   = we_q;
            if (we_q) begin
                mem_strb_o  = mask_q >> hi_shift;
                mem_wdata_o = wdata_q >> {hi_shift, 3'b000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_buf_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (req_valid_i) begin
                    we_q     <= req_we_i;
                    funct3_q <= req_funct3_i;
                    addr_q   <= req_addr_i;
                    wdata_q  <= req_wdata_i;
                    lo_buf_q <= '0;
                    rdata_q  <= '0;
                    err_q    <= req_err;
                end
                S_ACC0: if (!we_q) begin
                    lo_buf_q <= mem_rdata_i;
                    if (!cross_q) rdata_q <= load_extract({32'd0, mem_rdata_i}, off_q, funct3_q);
                end
                S_ACC1: if (!we_q) begin
                    rdata_q <= load_extract({mem_rdata_i, lo_buf_q}, off_q, funct3_q);
                end
                default: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && !rst;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: a split-enabled and a split-disabled unit share one word memory model.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_ns, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_strb;

    logic        req_ready_ns, resp_valid_ns, resp_err_ns, mem_we_ns;
    logic [31:0] resp_rdata_ns, mem_addr_ns, mem_wdata_ns, mem_rdata_ns;
    logic [3:0]  mem_strb_ns;

    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    resp_t       exp_q[$];
    resp_t       exp_ns_q[$];
    wr_t         wr_q[$];
    resp_t       e_main, e_ns;
    wr_t         w_main;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit #(.ADDR_WIDTH(32), .MEM_DEPTH(1024), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_strb_o(mem_strb), .mem_rdata_i(mem_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(32), .MEM_DEPTH(1024), .SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_ns), .req_ready_o(req_ready_ns), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid_ns), .resp_rdata_o(resp_rdata_ns), .resp_err_o(resp_err_ns),
        .mem_we_o(mem_we_ns), .mem_addr_o(mem_addr_ns), .mem_wdata_o(mem_wdata_ns),
        .mem_strb_o(mem_strb_ns), .mem_rdata_i(mem_rdata_ns)
    );

    assign mem_rdata    = mem_we    ? 32'd0 : mem[mem_addr[11:2]];
    assign mem_rdata_ns = mem_we_ns ? 32'd0 : mem[mem_addr_ns[11:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_strb == 4'd0 || mem_strb[b])
                    mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: got rdata %h err %b expected none (cycle %0d)",
                         resp_rdata, resp_err, cyc);
            end else begin
                e_main = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e_main.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e_main.err});
                check("resp_cycle", cyc, e_main.cyc);
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %h strb %b data %h expected none",
                         mem_addr, mem_strb, mem_wdata);
            end else begin
                w_main = wr_q.pop_front();
                check("wr_addr", mem_addr, w_main.addr);
                check("wr_strb", {28'd0, mem_strb}, {28'd0, w_main.strb});
                check("wr_data", mem_wdata, w_main.wdata);
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid_ns) begin
            if (exp_ns_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp_ns: got rdata %h err %b expected none",
                         resp_rdata_ns, resp_err_ns);
            end else begin
                e_ns = exp_ns_q.pop_front();
                check("ns_resp_rdata", resp_rdata_ns, e_ns.rdata);
                check("ns_resp_err", {31'd0, resp_err_ns}, {31'd0, e_ns.err});
                check("ns_resp_cycle", cyc, e_ns.cyc);
            end
        end
        if (mem_we_ns) begin
            checks++;
            $display("FAIL unexpected_write_ns: got addr %h expected none", mem_addr_ns);
        end
    end

    task automatic exp_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
        wr_t w;
        w.addr = addr; w.strb = strb; w.wdata = wdata;
        wr_q.push_back(w);
    endtask

    // lat < 0: no response expected (request will be aborted by reset)
    task automatic issue(input bit ns, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input bit exp_err, input int lat);
        int    waited;
        resp_t r;
        waited = 0;
        @(negedge clk);
        while (!(ns ? req_ready_ns : req_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            checks++;
            $display("FAIL issue_timeout: ready stayed 0 for %0d cycles, expected 1", waited);
            return;
        end
        if (lat >= 0) begin
            r.rdata = exp_rdata; r.err = exp_err; r.cyc = cyc + lat;
            if (ns) exp_ns_q.push_back(r);
            else exp_q.push_back(r);
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (ns) req_valid_ns = 1'b1;
        else req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_valid_ns = 1'b0;
        // scrambled inputs while busy must be ignored
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        rst = 1'b1;
        req_valid = 1'b0; req_valid_ns = 1'b0;
        req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        check("resp_valid_in_reset", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, req_ready}, 32'd1);
        check("resp_err_after_reset", {31'd0, resp_err}, 32'd0);
        check("resp_rdata_after_reset", resp_rdata, 32'd0);
        check("mem_we_after_reset", {31'd0, mem_we}, 32'd0);

        // aligned word, byte lanes, extension
        exp_wr(32'h10, 4'b1111, 32'hDEADBEEF);
        issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
        exp_wr(32'h10, 4'b1000, 32'hA5000000);
        issue(0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, 2);
        issue(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 0, 2);
        issue(0, 0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 0, 2);
        issue(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFA5AD, 0, 2);
        issue(0, 0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0, 2);

        // word-crossing accesses
        exp_wr(32'h04, 4'b1100, 32'h33440000);
        exp_wr(32'h08, 4'b0011, 32'h00001122);
        issue(0, 1, 3'b010, 32'h06, 32'h11223344, 32'h0, 0, 3);
        issue(0, 0, 3'b010, 32'h06, 32'h0, 32'h11223344, 0, 3);
        issue(0, 0, 3'b101, 32'h07, 32'h0, 32'h00002233, 0, 3);
        exp_wr(32'h04, 4'b1000, 32'hCD000000);
        exp_wr(32'h08, 4'b0001, 32'h000000AB);
        issue(0, 1, 3'b001, 32'h07, 32'h0000ABCD, 32'h0, 0, 3);
        issue(0, 0, 3'b001, 32'h07, 32'h0, 32'hFFFFABCD, 0, 3);
        issue(0, 0, 3'b101, 32'h07, 32'h0, 32'h0000ABCD, 0, 3);

        // decode errors and range boundary
        issue(0, 0, 3'b011, 32'h00, 32'h0, 32'h0, 1, 1);
        issue(0, 1, 3'b100, 32'h00, 32'h12345678, 32'h0, 1, 1);
        issue(0, 1, 3'b010, 32'hFFE, 32'hCAFEF00D, 32'h0, 1, 1);
        issue(0, 0, 3'b010, 32'hFFE, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 3'b010, 32'hFFC, 32'h0, 32'h0, 0, 2);
        check("mem_top_unchanged", mem[1023], 32'd0);

        // split enabled vs disabled
        exp_wr(32'h00, 4'b1111, 32'h80017FFF);
        issue(0, 1, 3'b010, 32'h00, 32'h80017FFF, 32'h0, 0, 2);
        issue(0, 0, 3'b001, 32'h02, 32'h0, 32'hFFFF8001, 0, 2);
        issue(1, 0, 3'b001, 32'h02, 32'h0, 32'hFFFF8001, 0, 2);
        issue(1, 0, 3'b001, 32'h03, 32'h0, 32'h0, 1, 1);
        issue(0, 0, 3'b001, 32'h03, 32'h0, 32'h00000080, 0, 3);

        // reset during the second half of a split store
        exp_wr(32'h04, 4'b1100, 32'h77880000);
        issue(0, 1, 3'b010, 32'h06, 32'h55667788, 32'h0, 0, -1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("ready_during_rst", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", {31'd0, req_ready}, 32'd1);
        check("resp_valid_after_abort", {31'd0, resp_valid}, 32'd0);
        check("word04_committed", mem[1], 32'h77880000);
        check("word08_untouched", mem[2], 32'h000011AB);

        repeat (8) @(negedge clk);
        check("resp_queue_drained", exp_q.size(), 32'd0);
        check("ns_queue_drained", exp_ns_q.size(), 32'd0);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
